// File: rtl/manchester_pkg.sv
// Shared types and helpers for the Manchester transmitter.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;

    localparam logic POL_THOMAS = 1'b0;
    localparam logic POL_IEEE   = 1'b1;

    // Line level for one half of a bit cell; half=0 is the first half.
    function automatic logic encode_half(input logic b, input logic polarity, input logic half);
        logic first;
        first = (polarity == POL_IEEE) ? ~b : b;
        return half ? ~first : first;
    endfunction

endpackage

// File: rtl/manchester_half_bit_timer.sv
// Half-bit cycle counter and half flag; flags the last cycle of each half and of each bit.
module manchester_half_bit_timer #(
    parameter int HALF_BIT_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic half,
    output logic half_end,
    output logic bit_end,
    output logic bit_end_nxt
);

    localparam int CNT_W = (HALF_BIT_CYC > 1) ? $clog2(HALF_BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BIT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             half_q, half_d;

    always_comb begin
        half_end = (cnt_q == CNT_LAST);
        bit_end  = half_end && half_q;
        cnt_d    = cnt_q + CNT_W'(1);
        half_d   = half_q;
        if (restart) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end else if (half_end) begin
            // wrap before incrementing so a one-cycle half never overflows
            cnt_d  = '0;
            half_d = ~half_q;
        end
        bit_end_nxt = (cnt_d == CNT_LAST) && half_d;
        half        = half_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/manchester_tx.sv
// Manchester transmitter: valid/ready word intake, optional alternating preamble, registered line output.
//   state    | meaning
//   IDLE     | line at IDLE_LEVEL, ready for a word
//   PREAMBLE | sending alternating 1,0,... preamble bits
//   DATA     | sending latched payload bits; last cycle may accept the next word
module manchester_tx
    import manchester_pkg::*;
#(
    parameter int   DATA_W       = 8,
    parameter int   HALF_BIT_CYC = 4,
    parameter int   PREAMBLE_LEN = 0,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              polarity,
    input  logic              msb_first,
    output logic              tx_out,
    output logic              tx_active,
    output logic              done
);

    localparam int CNT_MAX = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              pol_q, pol_d;
    logic              msb_q, msb_d;
    logic              s_ready_q, s_ready_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_active_q, tx_active_d;
    logic              done_q, done_d;

    logic accept, restart;
    logic half, half_end, bit_end, bit_end_nxt;
    logic half_nxt, cur_bit;

    assign accept  = s_valid && s_ready_q;
    assign restart = accept || (state_q == IDLE);

    manchester_half_bit_timer #(
        .HALF_BIT_CYC (HALF_BIT_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .half        (half),
        .half_end    (half_end),
        .bit_end     (bit_end),
        .bit_end_nxt (bit_end_nxt)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pol_d     = pol_q;
        msb_d     = msb_q;
        case (state_q)
            PREAMBLE: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == PRE_LAST) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        shift_d   = msb_q ? (shift_q << 1) : (shift_q >> 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // ready is only high in IDLE or the final cycle, so this also chains frames
        if (accept) begin
            state_d   = (PREAMBLE_LEN > 0) ? PREAMBLE : DATA;
            bit_cnt_d = '0;
            shift_d   = s_data;
            pol_d     = polarity;
            msb_d     = msb_first;
        end
    end

    // Output registers are loaded from next-state so they line up with the frame cycle.
    always_comb begin
        half_nxt = restart ? 1'b0 : (half ^ half_end);
        cur_bit  = IDLE_LEVEL;
        case (state_d)
            PREAMBLE: cur_bit = ~bit_cnt_d[0];
            DATA:     cur_bit = msb_d ? shift_d[DATA_W-1] : shift_d[0];
            default:  cur_bit = IDLE_LEVEL;
        endcase
        tx_out_d    = (state_d == IDLE) ? IDLE_LEVEL : encode_half(cur_bit, pol_d, half_nxt);
        tx_active_d = (state_d != IDLE);
        done_d      = (state_d == DATA) && (bit_cnt_d == DATA_LAST) && bit_end_nxt;
        s_ready_d   = (state_d == IDLE) || done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pol_q       <= 1'b0;
            msb_q       <= 1'b0;
            s_ready_q   <= 1'b0;
            tx_out_q    <= IDLE_LEVEL;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pol_q       <= pol_d;
            msb_q       <= msb_d;
            s_ready_q   <= s_ready_d;
            tx_out_q    <= tx_out_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign tx_out    = tx_out_q;
    assign tx_active = tx_active_q;
    assign done      = done_q;

endmodule

// File: tb/tb_manchester_tx.sv
// Scoreboard bench: accepted words expand into per-cycle expected line levels, a monitor compares each cycle.
module tb_manchester_tx;

    localparam int   DW   = 8;
    localparam int   HB   = 2;
    localparam int   PL   = 3;
    localparam logic IDLE = 1'b0;

    logic          clk, rst;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready, polarity, msb_first;
    logic          tx_out, tx_active, done;

    manchester_tx #(
        .DATA_W       (DW),
        .HALF_BIT_CYC (HB),
        .PREAMBLE_LEN (PL),
        .IDLE_LEVEL   (IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .polarity  (polarity),
        .msb_first (msb_first),
        .tx_out    (tx_out),
        .tx_active (tx_active),
        .done      (done)
    );

    typedef struct packed {
        logic tx;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference: list the bits of the frame, then expand each into two halves of HB cycles.
    task automatic push_frame(input logic [DW-1:0] d, input logic p, input logic m);
        int   total;
        logic b, lvl;
        total = PL + DW;
        for (int i = 0; i < total; i++) begin
            if (i < PL) b = (i % 2 == 0);
            else if (m) b = d[DW-1-(i-PL)];
            else        b = d[i-PL];
            for (int h = 0; h < 2; h++) begin
                lvl = (h == 0) ? (b ^ p) : ~(b ^ p);
                for (int c = 0; c < HB; c++)
                    exp_q.push_back('{tx: lvl, last: (i == total-1) && (h == 1) && (c == HB-1)});
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst && s_valid && s_ready)
            push_frame(s_data, polarity, msb_first);
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst) begin
                chk("rst_tx_out", tx_out, IDLE);
                chk("rst_tx_active", tx_active, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_s_ready", s_ready, 1'b0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tx_out", tx_out, e.tx);
                chk("tx_active", tx_active, 1'b1);
                chk("done", done, e.last);
                chk("s_ready", s_ready, e.last);
            end else begin
                chk("idle_tx_out", tx_out, IDLE);
                chk("idle_tx_active", tx_active, 1'b0);
                chk("idle_done", done, 1'b0);
                chk("idle_s_ready", s_ready, 1'b1);
            end
        end
    end

    // Offer a word and wait for the handshake; jit scrambles inputs while stalled.
    task automatic send(input logic [DW-1:0] d, input logic p, input logic m,
                        input logic keep, input logic jit);
        logic got;
        got = 1'b0;
        @(negedge clk);
        #1;
        s_valid   = 1'b1;
        s_data    = d;
        polarity  = p;
        msb_first = m;
        for (int k = 0; k < 500 && !got; k++) begin
            @(posedge clk);
            if (s_ready === 1'b1) got = 1'b1;
            else if (jit) begin
                #1;
                s_data    = DW'($urandom);
                polarity  = 1'($urandom);
                msb_first = 1'($urandom);
            end
        end
        chk("accept", got, 1'b1);
        #1;
        if (!keep) begin
            s_valid   = 1'b0;
            s_data    = DW'($urandom);
            polarity  = 1'($urandom);
            msb_first = 1'($urandom);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drain", exp_q.size() == 0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        polarity  = 1'b0;
        msb_first = 1'b1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();

        // back-to-back with s_valid held high throughout
        send(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        send(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // abort mid-frame with an asynchronous reset
        send(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_tx_out", tx_out, IDLE);
        chk("abort_tx_active", tx_active, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_s_ready", s_ready, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        send(8'h96, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // backpressure: word offered mid-frame with inputs changing until accepted
        send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        send(8'hE7, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        for (int n = 0; n < 30; n++) begin
            logic keep, jit;
            keep = ($urandom_range(0, 2) == 0);
            jit  = ($urandom_range(0, 3) == 0);
            send(DW'($urandom), 1'($urandom), 1'($urandom), keep, jit);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        s_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
